// File: rtl/ws2801_receiver.sv
// One WS2801 pixel: captures the first 24 bits of a frame as {R,G,B}, forwards the rest
// downstream on sdo/cko, and latches the colour after a 500 us idle gap on cki.
module ws2801_receiver #(
    parameter int FREQ         = 12_500_000,
    parameter int LATCH_CYCLES = FREQ / 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdi,
    input  logic        cki,
    output logic        sdo,
    output logic        cko,
    output logic [23:0] rgb,
    output logic        rgb_valid,
    output logic        frame_error,
    output logic        busy
);

    localparam int CW = $clog2(LATCH_CYCLES + 1);
    localparam logic [CW-1:0] LATCH_MAX = CW'(LATCH_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        FULL    = 2'd2,
        FORWARD = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            sdi_m;
    logic            sdi_s;
    logic            cki_m;
    logic            cki_s;
    logic            cki_d;
    logic [CW-1:0]   idle_cnt;
    logic [4:0]      bit_cnt;
    logic [23:0]     shreg;
    logic            rise;
    logic            fall;
    logic            latch_evt;

    assign rise = cki_s & ~cki_d;
    assign fall = ~cki_s & cki_d;
    // A rising edge in the cycle the counter would saturate wins: no latch, bit is taken.
    assign latch_evt = ~rise && (idle_cnt == LATCH_MAX - CW'(1));
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (rise) next_state = SHIFT;
            end
            SHIFT: begin
                if (latch_evt)                      next_state = IDLE;
                else if (rise && bit_cnt == 5'd23)  next_state = FULL;
            end
            // Wait for a falling edge so cko never starts mid-way through a high phase.
            FULL: begin
                if (latch_evt)  next_state = IDLE;
                else if (fall)  next_state = FORWARD;
            end
            FORWARD: begin
                if (latch_evt) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdi_m       <= 1'b0;
            sdi_s       <= 1'b0;
            cki_m       <= 1'b0;
            cki_s       <= 1'b0;
            cki_d       <= 1'b0;
            sdo         <= 1'b0;
            cko         <= 1'b0;
            idle_cnt    <= '0;
            bit_cnt     <= 5'd0;
            shreg       <= 24'd0;
            rgb         <= 24'd0;
            rgb_valid   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            sdi_m       <= sdi;
            sdi_s       <= sdi_m;
            cki_m       <= cki;
            cki_s       <= cki_m;
            cki_d       <= cki_s;
            sdo         <= sdi_s;
            cko         <= (state == FORWARD) ? cki_s : 1'b0;
            rgb_valid   <= 1'b0;
            frame_error <= 1'b0;

            if (rise) begin
                idle_cnt <= '0;
            end else if (idle_cnt != LATCH_MAX) begin
                idle_cnt <= idle_cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    bit_cnt <= 5'd0;
                    if (rise) begin
                        shreg   <= {shreg[22:0], sdi_s};
                        bit_cnt <= 5'd1;
                    end
                end
                SHIFT: begin
                    if (latch_evt) begin
                        frame_error <= 1'b1;
                        shreg       <= 24'd0;
                        bit_cnt     <= 5'd0;
                    end else if (rise) begin
                        shreg   <= {shreg[22:0], sdi_s};
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                FULL, FORWARD: begin
                    if (latch_evt) begin
                        rgb       <= shreg;
                        rgb_valid <= 1'b1;
                        bit_cnt   <= 5'd0;
                    end
                end
                default: bit_cnt <= 5'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2801_receiver.sv
// Directed bench for a chain of three ws2801_receiver pixels driven at cki = clk/8.
module tb_ws2801_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sdi = 1'b0;
    logic        cki = 1'b0;

    logic        sdo0, cko0, valid0, ferr0, busy0;
    logic        sdo1, cko1, valid1, ferr1, busy1;
    logic        sdo2, cko2, valid2, ferr2, busy2;
    logic [23:0] rgb0, rgb1, rgb2;

    int n_checks = 0;
    int n_pass   = 0;

    int nv0 = 0, nv1 = 0, nv2 = 0;
    int nf0 = 0, nf1 = 0, nf2 = 0;
    int nr0 = 0, nr1 = 0;
    bit cko0_prev = 1'b0;
    bit cko1_prev = 1'b0;

    int v0_s, v1_s, v2_s, f0_s, f1_s, r0_s, r1_s;

    always #5 clk = ~clk;

    ws2801_receiver u0 (
        .clk(clk), .rst(rst), .sdi(sdi), .cki(cki),
        .sdo(sdo0), .cko(cko0), .rgb(rgb0), .rgb_valid(valid0),
        .frame_error(ferr0), .busy(busy0)
    );
    ws2801_receiver u1 (
        .clk(clk), .rst(rst), .sdi(sdo0), .cki(cko0),
        .sdo(sdo1), .cko(cko1), .rgb(rgb1), .rgb_valid(valid1),
        .frame_error(ferr1), .busy(busy1)
    );
    ws2801_receiver u2 (
        .clk(clk), .rst(rst), .sdi(sdo1), .cki(cko1),
        .sdo(sdo2), .cko(cko2), .rgb(rgb2), .rgb_valid(valid2),
        .frame_error(ferr2), .busy(busy2)
    );

    // Pulse and edge counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid0) nv0++;
        if (valid1) nv1++;
        if (valid2) nv2++;
        if (ferr0)  nf0++;
        if (ferr1)  nf1++;
        if (ferr2)  nf2++;
        if (cko0 && !cko0_prev) nr0++;
        if (cko1 && !cko1_prev) nr1++;
        cko0_prev = cko0;
        cko1_prev = cko1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sdi = b;
        cki = 1'b0;
        wait_clk(4);
        cki = 1'b1;
        wait_clk(4);
    endtask

    task automatic send_bits(input logic [71:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        cki = 1'b0;
        sdi = 1'b0;
        wait_clk(n);
    endtask

    task automatic snap();
        v0_s = nv0; v1_s = nv1; v2_s = nv2;
        f0_s = nf0; f1_s = nf1;
        r0_s = nr0; r1_s = nr1;
    endtask

    initial begin
        // Reset state
        wait_clk(3);
        check("rst_rgb",   {8'd0, rgb0}, 32'h0);
        check("rst_valid", {31'd0, valid0}, 32'h0);
        check("rst_ferr",  {31'd0, ferr0}, 32'h0);
        check("rst_sdo",   {31'd0, sdo0}, 32'h0);
        check("rst_cko",   {31'd0, cko0}, 32'h0);
        check("rst_busy",  {31'd0, busy0}, 32'h0);
        rst = 1'b1;
        wait_clk(3);

        // Single frame 0x800000, latch after the idle gap
        snap();
        send_bits({48'd0, 24'h800000}, 24);
        check("t1_busy_after_24", {31'd0, busy0}, 32'h1);
        idle(6240);
        check("t1_no_early_valid", nv0 - v0_s, 0);
        wait_clk(15);
        check("t1_valid_once", nv0 - v0_s, 1);
        check("t1_rgb", {8'd0, rgb0}, 32'h800000);
        check("t1_cko_silent", nr0 - r0_s, 0);
        check("t1_busy_idle", {31'd0, busy0}, 32'h0);

        // Three-pixel chain
        snap();
        send_bits({24'hFFFFFF, 24'h555555, 24'h000001}, 72);
        idle(6300);
        check("t2_rgb0", {8'd0, rgb0}, 32'hFFFFFF);
        check("t2_rgb1", {8'd0, rgb1}, 32'h555555);
        check("t2_rgb2", {8'd0, rgb2}, 32'h000001);
        check("t2_cko0_rises", nr0 - r0_s, 48);
        check("t2_cko1_rises", nr1 - r1_s, 24);
        check("t2_valid0", nv0 - v0_s, 1);
        check("t2_valid1", nv1 - v1_s, 1);
        check("t2_valid2", nv2 - v2_s, 1);

        // Partial frame is discarded
        snap();
        send_bits({62'd0, 10'h2AB}, 10);
        idle(6300);
        check("t3_ferr_once", nf0 - f0_s, 1);
        check("t3_no_valid", nv0 - v0_s, 0);
        check("t3_rgb_kept", {8'd0, rgb0}, 32'hFFFFFF);
        check("t3_busy", {31'd0, busy0}, 32'h0);

        // Rising edge 6249 clk after the previous one keeps the frame alive
        snap();
        send_bits({48'd0, 24'h0F0F0F}, 24);
        idle(6245);
        check("t4_no_valid_gap", nv0 - v0_s, 0);
        sdi = 1'b1;
        cki = 1'b1;
        wait_clk(2);
        check("t4_sdo_2clk", {31'd0, sdo0}, 32'h0);
        check("t4_cko_2clk", {31'd0, cko0}, 32'h0);
        wait_clk(1);
        check("t4_sdo_3clk", {31'd0, sdo0}, 32'h1);
        check("t4_cko_3clk", {31'd0, cko0}, 32'h1);
        wait_clk(3);
        idle(6300);
        check("t4_valid_once", nv0 - v0_s, 1);
        check("t4_rgb", {8'd0, rgb0}, 32'h0F0F0F);
        check("t4_ferr1", nf1 - f1_s, 1);

        // Reset in the middle of a frame
        snap();
        send_bits({60'd0, 12'hABC}, 12);
        cki = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(3);
        check("t5_busy_in_rst", {31'd0, busy0}, 32'h0);
        check("t5_rgb_in_rst", {8'd0, rgb0}, 32'h0);
        rst = 1'b1;
        wait_clk(3);
        send_bits({48'd0, 24'h123456}, 24);
        idle(6300);
        check("t5_rgb", {8'd0, rgb0}, 32'h123456);
        check("t5_no_ferr", nf0 - f0_s, 0);
        check("t5_valid_once", nv0 - v0_s, 1);

        // cki held high through bit 24: cko must wait for bit 25
        snap();
        send_bits({49'd0, 23'h555555}, 23);
        sdi = 1'b0;
        cki = 1'b0;
        wait_clk(4);
        cki = 1'b1;
        wait_clk(20);
        check("t6_cko_low_in_b24", {31'd0, cko0}, 32'h0);
        check("t6_no_rise_b24", nr0 - r0_s, 0);
        cki = 1'b0;
        wait_clk(4);
        check("t6_no_rise_after_fall", nr0 - r0_s, 0);
        sdi = 1'b1;
        cki = 1'b1;
        wait_clk(4);
        check("t6_rise_b25", nr0 - r0_s, 1);
        idle(6300);
        check("t6_rgb", {8'd0, rgb0}, 32'hAAAAAA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ws2801_receiver.md
Name: ws2801_receiver

Overview:
- Synthesizable model of one WS2801 pixel, the receiving end of the LED strip serial link (SDI/CKI in, SDO/CKO out).
- Captures the first 24 bits of a frame MSB-first as {red[7]..blue[0]}, forwards all later bits downstream, and latches the captured colour after a 500 us idle gap.
- Used in chains for driver loopback benches and as an on-board strip emulator for bring-up without physical LEDs.

Parameters:
- FREQ, 12_500_000, clk frequency in Hz.
- LATCH_CYCLES, FREQ/2000, idle clk cycles (500 us) with no CKI rising edge before a latch.

Ports:
- clk, input, 1, system clock; must be ≥4x the CKI bit rate.
- rst, input, 1, asynchronous active-low reset (rst=0 resets).
- sdi, input, 1, serial data in, asynchronous to clk.
- cki, input, 1, serial clock in, asynchronous to clk.
- sdo, output, 1, forwarded serial data.
- cko, output, 1, forwarded serial clock, gated.
- rgb, output, 24, latched colour {R[7:0],G[7:0],B[7:0]}.
- rgb_valid, output, 1, one-cycle pulse when rgb updates.
- frame_error, output, 1, one-cycle pulse when a partial frame (<24 bits) is discarded.
- busy, output, 1, high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst=0, async): rgb=0, rgb_valid=0, frame_error=0, sdo=0, cko=0, busy=0, bit_cnt=0, idle_cnt=0, state=IDLE.
- sdi and cki each pass through a 2-flop synchronizer (sdi_s, cki_s). A rising edge is detected from cki_s and its previous value, and the falling edge likewise.
- cki high and low phases must each be ≥2 clk; shorter pulses are undefined.
- On each rising edge, sdi_s is the sampled bit.
- idle_cnt:
  - Cleared on a rising edge.
  - Otherwise increments, saturating at LATCH_CYCLES.
  - Counts whether cki is high or low.
- States:
  - IDLE: bit_cnt=0. A rising edge shifts the bit into shreg[0] (shreg <= {shreg[22:0],bit}), sets bit_cnt=1 and goes to SHIFT.
  - SHIFT: each rising edge shifts and increments bit_cnt. The edge that makes bit_cnt=24 goes to FULL.
  - FULL: 24 bits held; cko stays 0. The next cki falling edge goes to FORWARD. This prevents a truncated high phase on cko.
  - FORWARD: cko <= cki_s (registered). Rising edges do not touch shreg.
- sdo <= sdi_s every cycle, regardless of state. sdo and cko are therefore 3 clk after the pins (2 sync + 1 output reg), keeping their relative alignment.
- cko is 0 in IDLE, SHIFT and FULL. The first 24 bits never reach downstream.
- Latch event: idle_cnt becomes LATCH_CYCLES in this cycle.
  - In FULL or FORWARD: rgb <= shreg and rgb_valid=1 on the next cycle for exactly 1 cycle, then state goes to IDLE and bit_cnt=0.
  - In SHIFT (1..23 bits): shreg is discarded, rgb is unchanged, frame_error pulses 1 cycle, then IDLE.
  - In IDLE: no event. While idle_cnt stays saturated there is no repeat pulse.
- A rising edge in the same cycle idle_cnt would reach LATCH_CYCLES takes priority: it clears the counter, no latch occurs, and the bit is processed.
- After a latch, the next rising edge starts a new frame in IDLE. rgb holds its value until the next successful latch.
- Bits beyond 24 in FORWARD are unlimited; no counter overflow occurs, since bit_cnt stops at 24.
- Reset asserted mid-frame: all registers go to reset values immediately. A partial shreg is lost and no pulses are produced.

Test Plan:
- After reset, drive 24 bits 0x800000 (cki = clk/8), then idle 6250+5 clk -> rgb_valid pulses once 1 cycle after idle_cnt hits 6250, rgb=0x800000, cko stays 0 throughout.
- Chain 3 instances and drive 72 bits {0xFFFFFF,0x555555,0x000001} -> after latch, rgb = 0xFFFFFF, 0x555555, 0x000001 respectively. Instance 0 cko shows exactly 48 rising edges; instance 1 shows 24.
- Drive 10 bits then idle 6300 clk -> frame_error pulses once, rgb keeps its previous value (e.g. 0x800000), busy returns 0.
- Drive 24 bits, idle exactly 6249 clk, then another rising edge -> no rgb_valid. The frame continues in FORWARD and the new bit appears on sdo/cko 3 clk after the pins.
- Pull rst low mid-frame after 12 bits, release, then send 0x123456 plus idle -> rgb=0x123456, no frame_error from the aborted frame.
- Hold cki high through the 24th bit and check cko -> cko first rises only at bit 25's edge, never during the bit-24 high phase.
